// File: rtl/video_text_writer_pkg.sv
// Shared geometry defaults, memory bases, command encodings and FSM states
// for the text-mode writer.
package video_pkg;

  localparam int          DEF_COLS      = 60;
  localparam int          DEF_ROWS      = 40;
  localparam int          DEF_ATTR_COLS = 40;
  localparam logic [11:0] DEF_CHAR_BASE = 12'h000;
  localparam logic [11:0] DEF_ATTR_BASE = 12'h9C0;

  localparam logic [7:0]  CH_LF    = 8'h0A;
  localparam logic [7:0]  CH_CR    = 8'h0D;
  localparam logic [7:0]  CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    OP_PUTC    = 2'd0,
    OP_SETPOS  = 2'd1,
    OP_PUTATTR = 2'd2,
    OP_CLEAR   = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_CHAR = 2'd1,
    ST_CLR_ATTR = 2'd2
  } state_t;

endpackage

// File: rtl/video_text_writer_if.sv
// Command handshake between a command source (master) and the text writer (slave).
interface video_text_writer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [5:0] cmd_col;
  logic [5:0] cmd_row;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_col, cmd_row,
    output cmd_ready
  );

endinterface

// File: rtl/video_text_writer_addr.sv
// Maps a row/column pair to character and attribute addresses. The line base
// is built from per-row-bit stride multiples, so no multiplier is needed.
module video_text_addr
  import video_pkg::*;
#(
  parameter int          COLS      = DEF_COLS,
  parameter int          ATTR_COLS = DEF_ATTR_COLS,
  parameter logic [11:0] CHAR_BASE = DEF_CHAR_BASE,
  parameter logic [11:0] ATTR_BASE = DEF_ATTR_BASE
) (
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  input  logic [5:0]  attr_col,
  output logic [11:0] char_addr,
  output logic [11:0] attr_addr
);

  logic [11:0] char_line;
  logic [11:0] attr_line;

  always_comb begin
    char_line = CHAR_BASE;
    attr_line = ATTR_BASE;
    for (int i = 0; i < 6; i++) begin
      if (row[i]) begin
        char_line = char_line + 12'(COLS << i);
        attr_line = attr_line + 12'(ATTR_COLS << i);
      end
    end
  end

  assign char_addr = char_line + {6'd0, col};
  assign attr_addr = attr_line + {6'd0, attr_col};

endmodule

// File: rtl/video_text_writer.sv
// Text-mode writer: turns PUTC/SETPOS/PUTATTR/CLEAR commands into registered
// single-byte writes on the shared character/attribute memory port.
module video_text_writer
  import video_pkg::*;
#(
  parameter int          COLS      = DEF_COLS,
  parameter int          ROWS      = DEF_ROWS,
  parameter int          ATTR_COLS = DEF_ATTR_COLS,
  parameter logic [11:0] CHAR_BASE = DEF_CHAR_BASE,
  parameter logic [11:0] ATTR_BASE = DEF_ATTR_BASE
) (
  input  logic               clk,
  input  logic               rst,
  video_text_writer_if.slave cmd,
  output logic               char_w_wrena,
  output logic [11:0]        char_w_addr,
  output logic [7:0]         char_w_data,
  output logic               busy,
  output logic [5:0]         cur_col,
  output logic [5:0]         cur_row
);

  localparam logic [5:0]  COL_MAX  = 6'(COLS - 1);
  localparam logic [5:0]  ROW_MAX  = 6'(ROWS - 1);
  localparam logic [5:0]  ACOL_MAX = 6'(ATTR_COLS - 1);
  localparam logic [11:0] CHAR_END = CHAR_BASE + 12'(COLS * ROWS - 1);
  localparam logic [11:0] ATTR_END = ATTR_BASE + 12'(ATTR_COLS * ROWS - 1);

  state_t      state;
  logic [7:0]  fill_attr;
  logic [5:0]  setpos_col;
  logic [5:0]  setpos_row;
  logic [5:0]  attr_col;
  logic [5:0]  next_row;
  logic [11:0] char_addr;
  logic [11:0] attr_addr;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);

  assign setpos_col = (cmd.cmd_col > COL_MAX)  ? COL_MAX  : cmd.cmd_col;
  assign setpos_row = (cmd.cmd_row > ROW_MAX)  ? ROW_MAX  : cmd.cmd_row;
  assign attr_col   = (cmd.cmd_col > ACOL_MAX) ? ACOL_MAX : cmd.cmd_col;
  assign next_row   = (cur_row == ROW_MAX) ? 6'd0 : cur_row + 6'd1;

  video_text_addr #(
    .COLS      (COLS),
    .ATTR_COLS (ATTR_COLS),
    .CHAR_BASE (CHAR_BASE),
    .ATTR_BASE (ATTR_BASE)
  ) u_addr (
    .row       (cur_row),
    .col       (cur_col),
    .attr_col  (attr_col),
    .char_addr (char_addr),
    .attr_addr (attr_addr)
  );

  // During a clear the registered write address doubles as the sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_col      <= 6'd0;
      cur_row      <= 6'd0;
      fill_attr    <= 8'd0;
      char_w_wrena <= 1'b0;
      char_w_addr  <= 12'd0;
      char_w_data  <= 8'd0;
    end else begin
      char_w_wrena <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            case (cmd_op_t'(cmd.cmd_op))
              OP_PUTC: begin
                if (cmd.cmd_data == CH_CR) begin
                  cur_col <= 6'd0;
                end else if (cmd.cmd_data == CH_LF) begin
                  cur_row <= next_row;
                end else begin
                  char_w_wrena <= 1'b1;
                  char_w_addr  <= char_addr;
                  char_w_data  <= cmd.cmd_data;
                  if (cur_col == COL_MAX) begin
                    cur_col <= 6'd0;
                    cur_row <= next_row;
                  end else begin
                    cur_col <= cur_col + 6'd1;
                  end
                end
              end
              OP_SETPOS: begin
                cur_col <= setpos_col;
                cur_row <= setpos_row;
              end
              OP_PUTATTR: begin
                char_w_wrena <= 1'b1;
                char_w_addr  <= attr_addr;
                char_w_data  <= cmd.cmd_data;
              end
              OP_CLEAR: begin
                fill_attr    <= cmd.cmd_data;
                state        <= ST_CLR_CHAR;
                char_w_wrena <= 1'b1;
                char_w_addr  <= CHAR_BASE;
                char_w_data  <= CH_SPACE;
              end
            endcase
          end
        end
        ST_CLR_CHAR: begin
          char_w_wrena <= 1'b1;
          if (char_w_addr == CHAR_END) begin
            state       <= ST_CLR_ATTR;
            char_w_addr <= ATTR_BASE;
            char_w_data <= fill_attr;
          end else begin
            char_w_addr <= char_w_addr + 12'd1;
            char_w_data <= CH_SPACE;
          end
        end
        ST_CLR_ATTR: begin
          if (char_w_addr == ATTR_END) begin
            state   <= ST_IDLE;
            cur_col <= 6'd0;
            cur_row <= 6'd0;
          end else begin
            char_w_wrena <= 1'b1;
            char_w_addr  <= char_w_addr + 12'd1;
            char_w_data  <= fill_attr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_text_writer.sv
// Directed and randomized checks of video_text_writer against a cursor/address
// model computed with plain arithmetic.
module tb_video_text_writer;

  localparam int COLS      = 60;
  localparam int ROWS      = 40;
  localparam int ATTR_COLS = 40;
  localparam int CHAR_BASE = 'h000;
  localparam int ATTR_BASE = 'h9C0;
  localparam int PUTC = 0, SETPOS = 1, PUTATTR = 2, CLEAR = 3;

  logic        clk;
  logic        rst;
  logic        char_w_wrena;
  logic [11:0] char_w_addr;
  logic [7:0]  char_w_data;
  logic        busy;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;

  int checks = 0;
  int errors = 0;
  int m_col  = 0;
  int m_row  = 0;

  video_text_writer_if cmd_if ();

  video_text_writer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if),
    .char_w_wrena (char_w_wrena),
    .char_w_addr  (char_w_addr),
    .char_w_data  (char_w_data),
    .busy         (busy),
    .cur_col      (cur_col),
    .cur_row      (cur_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: cursor as integers, addresses as row*stride+col.
  task automatic model_step(input int op, input int d, input int c, input int r,
                            output bit wr, output int addr);
    wr   = 1'b0;
    addr = 0;
    case (op)
      PUTC: begin
        if (d == 'h0D) m_col = 0;
        else if (d == 'h0A) m_row = (m_row + 1) % ROWS;
        else begin
          wr   = 1'b1;
          addr = CHAR_BASE + m_row * COLS + m_col;
          m_col++;
          if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
          end
        end
      end
      SETPOS: begin
        m_col = (c < COLS - 1) ? c : COLS - 1;
        m_row = (r < ROWS - 1) ? r : ROWS - 1;
      end
      PUTATTR: begin
        wr   = 1'b1;
        addr = ATTR_BASE + m_row * ATTR_COLS + ((c < ATTR_COLS - 1) ? c : ATTR_COLS - 1);
      end
      default: ;
    endcase
  endtask

  task automatic apply_stimulus(input int op, input int d, input int c, input int r);
    check_output("ready_before_cmd", cmd_if.cmd_ready, 1);
    cmd_if.cmd_op    = 2'(op);
    cmd_if.cmd_data  = 8'(d);
    cmd_if.cmd_col   = 6'(c);
    cmd_if.cmd_row   = 6'(r);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input int op, input int d, input int c, input int r);
    bit wr;
    int addr;
    apply_stimulus(op, d, c, r);
    model_step(op, d, c, r, wr, addr);
    check_output("wrena", char_w_wrena, wr);
    if (wr) begin
      check_output("addr", char_w_addr, addr);
      check_output("data", char_w_data, d & 'hFF);
    end
    check_output("cur_col", cur_col, m_col);
    check_output("cur_row", cur_row, m_row);
  endtask

  initial begin
    int bad;
    int gap_writes;
    int exp_addr;
    int exp_data;
    int op;
    int d;
    int wcount;
    int addr61;
    bit wr;
    int addr;

    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = 8'd0;
    cmd_if.cmd_col   = 6'd0;
    cmd_if.cmd_row   = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_wrena", char_w_wrena, 0);
    check_output("rst_addr", char_w_addr, 0);
    check_output("rst_data", char_w_data, 0);
    check_output("rst_ready", cmd_if.cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_col", cur_col, 0);
    check_output("rst_row", cur_row, 0);
    rst = 1'b0;

    $display("[TB] directed cursor and address cases");
    do_cmd(SETPOS, 0, 5, 3);
    do_cmd(PUTC, 'h41, 0, 0);
    check_output("d1_addr", char_w_addr, 'h0B9);
    check_output("d1_col", cur_col, 6);
    check_output("d1_row", cur_row, 3);

    do_cmd(SETPOS, 0, 59, 39);
    do_cmd(PUTC, 'h42, 0, 0);
    check_output("d2_addr", char_w_addr, 'h95F);
    check_output("d2_col", cur_col, 0);
    check_output("d2_row", cur_row, 0);
    do_cmd(SETPOS, 0, 7, 39);
    do_cmd(PUTC, 'h0A, 0, 0);
    check_output("d2_lf_row", cur_row, 0);
    check_output("d2_lf_col", cur_col, 7);
    do_cmd(PUTC, 'h0D, 0, 0);
    check_output("d2_cr_col", cur_col, 0);

    do_cmd(SETPOS, 0, 63, 63);
    check_output("d3_col", cur_col, 59);
    check_output("d3_row", cur_row, 39);
    do_cmd(PUTATTR, 'h07, 50, 0);
    check_output("d3_addr", char_w_addr, 'hFFF);
    check_output("d3_data", char_w_data, 'h07);

    $display("[TB] randomized command stream");
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 2);
      d  = $urandom_range(0, 255);
      if (op == PUTC && $urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 0) ? 'h0A : 'h0D;
      do_cmd(op, d, $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check_output("idle_wrena", char_w_wrena, 0);
      end
    end

    $display("[TB] back-to-back PUTC");
    do_cmd(SETPOS, 0, 0, 0);
    wcount = 0;
    addr61 = -1;
    cmd_if.cmd_op    = 2'(PUTC);
    cmd_if.cmd_data  = 8'h41;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      model_step(PUTC, 'h41 + (i % 26), 0, 0, wr, addr);
      if (char_w_wrena) wcount++;
      if (i == 60) addr61 = char_w_addr;
      check_output("b2b_addr", char_w_addr, addr);
      if (i < 69) cmd_if.cmd_data = 8'('h41 + ((i + 1) % 26));
      else cmd_if.cmd_valid = 1'b0;
    end
    check_output("b2b_writes", wcount, 70);
    check_output("b2b_61st_addr", addr61, 'h03C);
    @(posedge clk); #1;
    check_output("b2b_after_wrena", char_w_wrena, 0);

    $display("[TB] full clear with a held-off command");
    cmd_if.cmd_op    = 2'(CLEAR);
    cmd_if.cmd_data  = 8'h1F;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_op   = 2'(PUTC);
    cmd_if.cmd_data = 8'h55;
    bad        = 0;
    gap_writes = 0;
    for (int k = 0; k < 4000; k++) begin
      exp_addr = (k < COLS * ROWS) ? CHAR_BASE + k : ATTR_BASE + (k - COLS * ROWS);
      exp_data = (k < COLS * ROWS) ? 'h20 : 'h1F;
      if (cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1 || char_w_wrena !== 1'b1 ||
          char_w_addr !== 12'(exp_addr) || char_w_data !== 8'(exp_data)) bad++;
      if (char_w_wrena && char_w_addr >= 12'h960 && char_w_addr <= 12'h9BF) gap_writes++;
      if (k < 3999) begin
        @(posedge clk); #1;
      end
    end
    check_output("clear_bad_cycles", bad, 0);
    check_output("clear_gap_writes", gap_writes, 0);
    check_output("clear_last_addr", char_w_addr, 'hFFF);
    @(posedge clk); #1;
    m_col = 0;
    m_row = 0;
    check_output("clear_end_wrena", char_w_wrena, 0);
    check_output("clear_end_ready", cmd_if.cmd_ready, 1);
    check_output("clear_end_col", cur_col, 0);
    check_output("clear_end_row", cur_row, 0);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    model_step(PUTC, 'h55, 0, 0, wr, addr);
    check_output("held_wrena", char_w_wrena, 1);
    check_output("held_addr", char_w_addr, addr);
    check_output("held_data", char_w_data, 'h55);
    check_output("held_col", cur_col, m_col);

    $display("[TB] clear aborted by reset");
    do_cmd(SETPOS, 0, 10, 10);
    cmd_if.cmd_op    = 2'(CLEAR);
    cmd_if.cmd_data  = 8'h33;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (999) begin
      @(posedge clk); #1;
    end
    check_output("abort_w1000_addr", char_w_addr, CHAR_BASE + 999);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_col = 0;
    m_row = 0;
    check_output("abort_wrena", char_w_wrena, 0);
    check_output("abort_ready", cmd_if.cmd_ready, 1);
    check_output("abort_col", cur_col, 0);
    check_output("abort_row", cur_row, 0);
    do_cmd(PUTC, 'h61, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_text_writer.md
VIDEO_TEXT_WRITER -- requirements
Module: video_text_writer

Interface
REQ-001 Parameter COLS, default 60: character columns per row; equals the character line stride.
REQ-002 Parameter ROWS, default 40: text rows.
REQ-003 Parameter ATTR_COLS, default 40: attribute bytes per row; equals the attribute line stride.
REQ-004 Parameter CHAR_BASE, default 12'h000: character area base address.
REQ-005 Parameter ATTR_BASE, default 12'h9C0: attribute area base address.
REQ-006 clk  in  1: the only clock; all state changes on its rising edge.
REQ-007 rst  in  1: reset; synchronous, active-high.
REQ-008 cmd_valid  in  1: a command is presented.
REQ-009 cmd_ready  out  1: the block accepts a command this cycle.
REQ-010 cmd_op  in  2: operation code; 0 PUTC, 1 SETPOS, 2 PUTATTR, 3 CLEAR.
REQ-011 cmd_data  in  8: character code (PUTC) or attribute byte (PUTATTR, CLEAR).
REQ-012 cmd_col  in  6: column for SETPOS; attribute index for PUTATTR.
REQ-013 cmd_row  in  6: row for SETPOS.
REQ-014 char_w_wrena  out  1: write strobe to the char/attr memory, one byte per cycle.
REQ-015 char_w_addr  out  12: write address.
REQ-016 char_w_data  out  8: write data.
REQ-017 busy  out  1: a CLEAR is in progress.
REQ-018 cur_col  out  6, cur_row  out  6: current cursor position.

Function
REQ-019 A command SHALL be accepted only in a cycle where cmd_valid and cmd_ready are both high.
REQ-020 cmd_ready SHALL equal "state is IDLE"; busy SHALL be its inverse.
REQ-021 All memory-side outputs SHALL be registered; the write for an accepted command SHALL appear exactly 1 cycle after acceptance.
REQ-022 char_w_wrena SHALL be high for exactly one cycle per written byte and low otherwise.
REQ-023 PUTC for codes other than 0x0A and 0x0D SHALL:
- write cmd_data to CHAR_BASE + cur_row*COLS + cur_col;
- advance the cursor: col+1; at col COLS-1, col becomes 0 and row advances; at row ROWS-1, row wraps to 0.
REQ-024 PUTC 0x0D SHALL set col to 0, write nothing.
REQ-025 PUTC 0x0A SHALL advance row with the same wrap rule, keep col unchanged, write nothing.
REQ-026 SETPOS SHALL set col to min(cmd_col, COLS-1) and row to min(cmd_row, ROWS-1), write nothing.
REQ-027 PUTATTR SHALL write cmd_data to ATTR_BASE + cur_row*ATTR_COLS + min(cmd_col, ATTR_COLS-1); the cursor SHALL be unchanged.
REQ-028 CLEAR SHALL latch cmd_data as the fill attribute and step through three states:
- IDLE -> CLR_CHAR: write 0x20 to every char address CHAR_BASE .. CHAR_BASE+COLS*ROWS-1, ascending, one per cycle;
- CLR_CHAR -> CLR_ATTR: write the fill attribute to ATTR_BASE .. ATTR_BASE+ATTR_COLS*ROWS-1, ascending;
- CLR_ATTR -> IDLE: the cursor SHALL be set to (0,0).
REQ-029 CLEAR SHALL take exactly COLS*ROWS + ATTR_COLS*ROWS write cycles (4000 at defaults) with no gaps.
REQ-030 With defaults, the last attribute address SHALL be 12'hFFF, and addresses 12'h960..12'h9BF SHALL never be written.
REQ-031 Address arithmetic SHALL be 12-bit unsigned; an address outside the selected area SHALL never be generated.
REQ-032 Commands presented while busy SHALL be held off via cmd_ready low, not dropped.

Reset
REQ-033 On rst: state IDLE; cur_col=0, cur_row=0; char_w_wrena=0, char_w_addr=0, char_w_data=0. cmd_ready=1 and busy=0 follow from state IDLE.
REQ-034 rst during CLEAR SHALL abort it at once; no write SHALL occur in the cycle after rst.

Structure
REQ-035 The package video_pkg SHALL hold the default geometry constants, the CHAR_BASE and ATTR_BASE constants, the cmd_op encodings and the state enumeration.
REQ-036 One sub-module, video_text_addr, SHALL map row/col to char and attr addresses. It SHALL use incremental line bases, with no multipliers.

Verification
REQ-037 Reset, SETPOS(5,3), PUTC 0x41 -> one cycle later: wrena=1, addr=12'h0B9, data=0x41; cursor becomes (6,3).
REQ-038 SETPOS(59,39), PUTC 0x42 -> addr=12'h95F; cursor becomes (0,0). Then PUTC 0x0A at row 39 -> row 0, no write.
REQ-039 SETPOS(63,63) -> cursor (59,39). Then PUTATTR col=50, data=0x07 -> addr=12'hFFF, data=0x07.
REQ-040 CLEAR data=0x1F -> ready low for 4000 cycles:
- 2400 writes of 0x20 at 12'h000..12'h95F;
- 1600 writes of 0x1F at 12'h9C0..12'hFFF;
- then ready high and cursor (0,0).
REQ-041 CLEAR with rst asserted at write 1000 -> next cycle wrena=0, ready=1, cursor (0,0).
REQ-042 Back-to-back PUTC with cmd_valid held high for 70 cycles -> 70 consecutive write cycles; the 61st write lands at row 1, col 0 (addr 12'h03C).
